mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/lc3b_types.sv | 53 +++++
 rtl/mem_access_if.sv | 31 +++
 rtl/mem_format.sv | 50 +++++
 rtl/mem_access.sv | 129 ++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the MEM stage: word type, memory operation encoding,
// MEM-stage FSM states, the latched request payload, and op-classification helpers.
package lc3b_types;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BE_W   = 2;

  typedef logic [WORD_W-1:0] lc3b_word;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LD   = 3'd1,
    MEM_ST   = 3'd2,
    MEM_LDB  = 3'd3,
    MEM_STB  = 3'd4,
    MEM_LDI  = 3'd5,
    MEM_STI  = 3'd6
  } lc3b_mem_op;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS1 = 2'd1,
    ACCESS2 = 2'd2,
    DONE    = 2'd3
  } mem_state_e;

  // Request captured from EX/MEM when the FSM accepts it.
  typedef struct packed {
    lc3b_mem_op op;
    lc3b_word   addr;
    lc3b_word   data;
  } mem_req_t;

  // Byte-granular ops keep the raw address; everything else is word aligned.
  function automatic logic op_is_byte(input lc3b_mem_op op);
    return (op == MEM_LDB) || (op == MEM_STB);
  endfunction

  // LDI/STI fetch a pointer first, then perform a second access through it.
  function automatic logic op_is_indirect(input lc3b_mem_op op);
    return (op == MEM_LDI) || (op == MEM_STI);
  endfunction

  // Only ST and STB write on the first access; STI reads its pointer first.
  function automatic logic op_first_write(input lc3b_mem_op op);
    return (op == MEM_ST) || (op == MEM_STB);
  endfunction

  function automatic logic op_is_load(input lc3b_mem_op op);
    return (op == MEM_LD) || (op == MEM_LDB) || (op == MEM_LDI);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline-side and memory-side signals of the MEM stage.
// slave  : view of mem_access (consumes request + memory response, drives bus + stall).
// master : view of the surrounding pipeline/memory model.
interface mem_access_if;
  import lc3b_types::*;

  logic                  req_valid;
  lc3b_mem_op            mem_op;
  lc3b_word              mar_in;
  lc3b_word              mdr_in;
  lc3b_word              mem_rdata;
  logic                  mem_resp;
  lc3b_word              mem_address;
  lc3b_word              mem_wdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [BE_W-1:0]       mem_byte_enable;
  logic                  stall;
  lc3b_word              data_out;

  modport slave (
    input  req_valid, mem_op, mar_in, mdr_in, mem_rdata, mem_resp,
    output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable, stall, data_out
  );

  modport master (
    output req_valid, mem_op, mar_in, mdr_in, mem_rdata, mem_resp,
    input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable, stall, data_out
  );

endinterface

// File: rtl/mem_format.sv
// Combinational byte/word formatting for the MEM stage.
// Ports: op (latched op), active/is_write (current strobe), addr (address for this
// access), mdr (store data), rdata (memory read data);
// address_c, wdata_c, byte_enable_c (memory bus), load_data_c (value for data_out).
module mem_format
  import lc3b_types::*;
(
  input  lc3b_mem_op      op,
  input  logic            active,
  input  logic            is_write,
  input  lc3b_word        addr,
  input  lc3b_word        mdr,
  input  lc3b_word        rdata,
  output lc3b_word        address_c,
  output lc3b_word        wdata_c,
  output logic [BE_W-1:0] byte_enable_c,
  output lc3b_word        load_data_c
);

  logic byte_op;

  assign byte_op = op_is_byte(op);

  // Word accesses drop address bit 0; byte accesses use it to pick a lane.
  assign address_c = byte_op ? addr : {addr[WORD_W-1:1], 1'b0};

  // A byte store replicates the low byte so either lane sees it.
  assign wdata_c = (op == MEM_STB) ? {mdr[7:0], mdr[7:0]} : mdr;

  // Lanes only matter while a strobe is up; idle bus shows no lanes.
  always_comb begin
    byte_enable_c = '0;
    if (active) begin
      if (is_write && (op == MEM_STB)) begin
        byte_enable_c = addr[0] ? 2'b10 : 2'b01;
      end else begin
        byte_enable_c = 2'b11;
      end
    end
  end

  // LDB zero-extends the addressed byte; word loads pass through.
  always_comb begin
    load_data_c = rdata;
    if (op == MEM_LDB) begin
      load_data_c = addr[0] ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_access.sv
// LC-3b MEM stage: sequences LD/ST/LDB/STB/LDI/STI against a handshake memory.
// Ports: clk, reset_n (async, active low), bus (mem_access_if.slave) carrying the
// EX/MEM request, memory bus, stall back to the pipeline and the formatted load data.
module mem_access
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset_n,
  mem_access_if.slave  bus
);

  mem_state_e      state_q, state_d;
  mem_req_t        req_q;
  lc3b_word        ptr_q;
  lc3b_word        data_out_q;

  logic            stall_c;
  logic            read_c;
  logic            write_c;
  logic            second_c;
  logic            req_we_c;
  logic            ptr_we_c;
  logic            data_we_c;

  lc3b_word        access_addr;
  lc3b_word        fmt_address;
  lc3b_word        fmt_wdata;
  logic [BE_W-1:0] fmt_be;
  lc3b_word        fmt_load;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      ptr_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_we_c) begin
        req_q <= '{op: bus.mem_op, addr: bus.mar_in, data: bus.mdr_in};
      end
      if (ptr_we_c) begin
        ptr_q <= bus.mem_rdata;
      end
      if (data_we_c) begin
        data_out_q <= fmt_load;
      end
    end
  end

  // Next-state, strobe and stall decode from state and the latched op.
  always_comb begin
    state_d   = state_q;
    stall_c   = 1'b0;
    read_c    = 1'b0;
    write_c   = 1'b0;
    second_c  = 1'b0;
    req_we_c  = 1'b0;
    ptr_we_c  = 1'b0;
    data_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        // Accepting stalls upstream in the same cycle so EX/MEM holds.
        if (bus.req_valid && (bus.mem_op != MEM_NONE)) begin
          req_we_c = 1'b1;
          stall_c  = 1'b1;
          state_d  = ACCESS1;
        end
      end
      ACCESS1: begin
        stall_c = 1'b1;
        write_c = op_first_write(req_q.op);
        read_c  = !op_first_write(req_q.op);
        if (bus.mem_resp) begin
          if (op_is_indirect(req_q.op)) begin
            ptr_we_c = 1'b1;
            state_d  = ACCESS2;
          end else begin
            data_we_c = op_is_load(req_q.op);
            state_d   = DONE;
          end
        end
      end
      ACCESS2: begin
        stall_c  = 1'b1;
        second_c = 1'b1;
        read_c   = (req_q.op == MEM_LDI);
        write_c  = (req_q.op == MEM_STI);
        if (bus.mem_resp) begin
          data_we_c = (req_q.op == MEM_LDI);
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Second access of LDI/STI goes through the fetched pointer.
  assign access_addr = second_c ? ptr_q : req_q.addr;

  mem_format u_fmt (
    .op            (req_q.op),
    .active        (read_c | write_c),
    .is_write      (write_c),
    .addr          (access_addr),
    .mdr           (req_q.data),
    .rdata         (bus.mem_rdata),
    .address_c     (fmt_address),
    .wdata_c       (fmt_wdata),
    .byte_enable_c (fmt_be),
    .load_data_c   (fmt_load)
  );

  // IDLE stall follows the live request, so reset must mask it directly.
  assign bus.stall           = stall_c & reset_n;
  assign bus.mem_read        = read_c;
  assign bus.mem_write       = write_c;
  assign bus.mem_byte_enable = fmt_be;
  assign bus.mem_address     = fmt_address;
  assign bus.mem_wdata       = fmt_wdata;
  assign bus.data_out        = data_out_q;

endmodule
